// File: rtl/keypad_digit_display.sv
// keypad_digit_display
//
// Consumer side of the keypad encoder. Each new key press (rising edge of
// valid with a legal BCD code and entry enabled) shifts one digit into a
// 4-digit MM:SS entry buffer. The buffer is shown on a time-multiplexed,
// active-low 4-digit 7-segment display with leading-digit blanking.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   bcd[3:0]     encoder digit code (0..9 legal)
//   valid        encoder valid level, high while a key is held
//   enablen      active-low entry enable (high blocks entry)
//   clr          synchronous clear of the entry buffer
//   time_bcd     {m1,m0,s1,s0} BCD, s0 newest
//   digit_count  digits entered, 0..4 saturating
//   new_digit    one-cycle pulse per accepted digit
//   seg          {g,f,e,d,c,b,a}, active-low
//   an           one-hot active-low anode select, an[0] is s0
module keypad_digit_display #(
    parameter int SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  bcd,
    input  logic        valid,
    input  logic        enablen,
    input  logic        clr,
    output logic [15:0] time_bcd,
    output logic [2:0]  digit_count,
    output logic        new_digit,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int DIV_W = $clog2(SCAN_DIV);

    logic             valid_q;
    logic             accept;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       idx;
    logic [3:0]       cur_nibble;
    logic             blank;
    logic [6:0]       seg_next;

    // Rising edge of valid only: a held key yields exactly one accept, and a
    // key already held when enablen falls is not seen as a new press.
    assign accept = valid & ~valid_q & ~enablen & (bcd <= 4'd9);

    // Entry buffer
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            time_bcd    <= 16'h0000;
            digit_count <= 3'd0;
            new_digit   <= 1'b0;
        end else begin
            valid_q   <= valid;
            new_digit <= 1'b0;
            if (clr) begin
                // clr wins over a same-cycle accept; that digit is dropped.
                time_bcd    <= 16'h0000;
                digit_count <= 3'd0;
            end else if (accept) begin
                time_bcd  <= {time_bcd[11:0], bcd};
                new_digit <= 1'b1;
                if (digit_count != 3'd4) begin
                    digit_count <= digit_count + 3'd1;
                end
            end
        end
    end

    // Scan divider and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= 2'd0;
        end else if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
            div_cnt <= '0;
            idx     <= idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Segment decode of the currently scanned digit
    // NOTE: every signal driven here gets a default before the case so no
    // latch is inferred on unlisted codes.
    always_comb begin
        cur_nibble = time_bcd[{idx, 2'b00} +: 4];
        // Digit 0 is never blanked so an empty buffer still shows "0".
        blank      = (idx != 2'd0) && ({1'b0, idx} >= digit_count);
        seg_next   = 7'h7F;
        case (cur_nibble)
            4'd0: seg_next = 7'h40;
            4'd1: seg_next = 7'h79;
            4'd2: seg_next = 7'h24;
            4'd3: seg_next = 7'h30;
            4'd4: seg_next = 7'h19;
            4'd5: seg_next = 7'h12;
            4'd6: seg_next = 7'h02;
            4'd7: seg_next = 7'h78;
            4'd8: seg_next = 7'h00;
            4'd9: seg_next = 7'h10;
            default: seg_next = 7'h7F;
        endcase
    end

    // Registered display outputs, one cycle behind idx and time_bcd
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= blank ? 7'h7F : seg_next;
        end
    end

endmodule

// File: tb/tb_keypad_digit_display.sv
// Testbench for keypad_digit_display: directed test-plan sequence followed by
// a randomized phase, all checked against a digit-queue reference model.
module tb_keypad_digit_display;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  bcd;
    logic        valid;
    logic        enablen;
    logic        clr;
    logic [15:0] time_bcd;
    logic [2:0]  digit_count;
    logic        new_digit;
    logic [6:0]  seg;
    logic [3:0]  an;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    // Reference model: entered digits, oldest first, at most four kept.
    int q[$];
    bit prev_valid = 1'b0;
    int cyc = 0;          // edges since reset released
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_nd;

    keypad_digit_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst(rst), .bcd(bcd), .valid(valid), .enablen(enablen),
        .clr(clr), .time_bcd(time_bcd), .digit_count(digit_count),
        .new_digit(new_digit), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dec7(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;
            3: return 7'h30;  4: return 7'h19;  5: return 7'h12;
            6: return 7'h02;  7: return 7'h78;  8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Digit at display position p (0 = newest); absent positions read 0.
    function automatic int digit_at(input int p);
        if (p < q.size()) return q[q.size() - 1 - p];
        return 0;
    endfunction

    function automatic logic [15:0] model_time();
        logic [15:0] t = 16'h0000;
        for (int p = 0; p < 4; p++) t = t | (16'(digit_at(p)) << (4 * p));
        return t;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then compare.
    task automatic step(input logic r, input logic v, input logic [3:0] b,
                        input logic en_n, input logic c);
        int  idx;
        bit  acc;
        rst = r; valid = v; bcd = b; enablen = en_n; clr = c;
        @(posedge clk);
        if (r) begin
            q.delete();
            prev_valid = 1'b0;
            cyc     = 0;
            exp_an  = 4'b1111;
            exp_seg = 7'h7F;
            exp_nd  = 1'b0;
        end else begin
            // Display reflects the buffer as it was before this edge.
            idx     = (cyc / SCAN_DIV) % 4;
            exp_an  = ~(4'b0001 << idx);
            exp_seg = (idx != 0 && idx >= q.size()) ? 7'h7F : dec7(digit_at(idx));
            cyc++;
            acc    = v && !prev_valid && !en_n && (b <= 4'd9);
            exp_nd = acc && !c;
            if (c) q.delete();
            else if (acc) begin
                q.push_back(int'(b));
                if (q.size() > 4) void'(q.pop_front());
            end
            prev_valid = v;
        end
        #1;
        check("time_bcd", time_bcd, model_time());
        check("digit_count", {13'b0, digit_count}, 16'(q.size()));
        check("new_digit", {15'b0, new_digit}, {15'b0, exp_nd});
        check("an", {12'b0, an}, {12'b0, exp_an});
        check("seg", {9'b0, seg}, {9'b0, exp_seg});
        if (new_digit === 1'b1) pulses++;
    endtask

    task automatic press(input logic [3:0] d, input int hold, input int rel);
        repeat (hold) step(1'b0, 1'b1, d, 1'b0, 1'b0);
        repeat (rel)  step(1'b0, 1'b0, d, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset then idle: an rotates, only digit 0 lit as "0"
        repeat (3) step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        repeat (20) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        check("idle_time", time_bcd, 16'h0000);

        // Long hold of 1, then 2 and 3
        pulses = 0;
        press(4'd1, 50, 4);
        press(4'd2, 3, 3);
        press(4'd3, 3, 8);
        check("seq123_time", time_bcd, 16'h0123);
        check("seq123_count", {13'b0, digit_count}, 16'd3);
        check("seq123_pulses", 16'(pulses), 16'd3);

        // Five digits: oldest discarded, count saturates
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        pulses = 0;
        for (int d = 1; d <= 5; d++) press(4'(d), 2, 2);
        repeat (16) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        check("seq5_time", time_bcd, 16'h2345);
        check("seq5_count", {13'b0, digit_count}, 16'd4);
        check("seq5_pulses", 16'(pulses), 16'd5);

        // Key pressed while blocked, still held when enablen falls
        pulses = 0;
        repeat (5) step(1'b0, 1'b1, 4'd7, 1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b1, 4'd7, 1'b0, 1'b0);
        check("blocked_time", time_bcd, 16'h2345);
        check("blocked_pulses", 16'(pulses), 16'd0);
        press(4'd7, 0, 2);
        press(4'd7, 2, 2);
        check("repress_time", time_bcd, 16'h3457);
        check("repress_pulses", 16'(pulses), 16'd1);

        // Illegal code ignored
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        press(4'd4, 2, 2);
        press(4'd2, 2, 2);
        pulses = 0;
        press(4'hC, 3, 3);
        check("illegal_time", time_bcd, 16'h0042);
        check("illegal_pulses", 16'(pulses), 16'd0);

        // clr beats a same-cycle accept
        step(1'b0, 1'b1, 4'd9, 1'b0, 1'b1);
        check("clr_time", time_bcd, 16'h0000);
        check("clr_count", {13'b0, digit_count}, 16'd0);
        check("clr_nd", {15'b0, new_digit}, 16'd0);
        press(4'd9, 1, 6);

        // Reset mid-scan with a key held through reset release
        press(4'd6, 2, 1);
        step(1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
        check("rst_an", {12'b0, an}, 16'h000F);
        check("rst_seg", {9'b0, seg}, 16'h007F);
        step(1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
        pulses = 0;
        press(4'd5, 4, 4);
        check("held_rst_time", time_bcd, 16'h0005);
        check("held_rst_pulses", 16'(pulses), 16'd1);

        // Randomized traffic
        begin
            logic v = 1'b0;
            logic [3:0] b = 4'd0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    v = ~v;
                    if (v) b = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15))
                                                           : 4'($urandom_range(0, 9));
                end
                step($urandom_range(0, 199) == 0, v, b,
                     $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_digit_display.md
Name: keypad_digit_display

Overview:
- Consumer side of the keypad encoder interface. Takes the encoder's BCD code and valid level, one digit per key press.
- Shifts accepted digits into a 4-digit MM:SS time entry buffer.
- Drives a time-multiplexed, active-low 4-digit 7-segment display of that buffer, with leading-digit blanking.
- Sits between the keypad encoder and the cook timer/display in the microwave datapath.

Parameters:
- SCAN_DIV, 4, clk cycles each display digit stays lit; legal range is 2 or more.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- bcd  input  4  encoder digit code; only 0..9 is legal.
- valid  input  1  encoder valid level; high for as long as a key is held.
- enablen  input  1  active-low entry enable; high blocks entry (door open or cooking).
- clr  input  1  clear entry buffer; synchronous, one cycle is enough.
- time_bcd  output  16  {m1,m0,s1,s0} BCD; s0 is the newest digit.
- digit_count  output  3  number of digits entered, 0..4, saturating.
- new_digit  output  1  one-cycle pulse when a digit is accepted.
- seg  output  7  {g,f,e,d,c,b,a}, active-low.
- an  output  4  digit anode select, one-hot active-low; an[0] is s0.

Behaviour:
- Reset (rst=1 at an edge):
  - time_bcd=0, digit_count=0, new_digit=0, valid_q=0.
  - Scan divider=0, scan index=0.
  - an=4'b1111, seg=7'h7F.
- Press detection:
  - valid_q is a register of valid and updates every cycle, including when blocked or cleared.
  - accept = valid & ~valid_q & ~enablen & (bcd<=9).
- Accept, registered with 1-cycle latency:
  - time_bcd <= {time_bcd[11:0], bcd}.
  - digit_count <= min(digit_count+1, 4).
  - new_digit=1 for exactly one cycle.
- Fifth and later digits: the oldest digit (m1) is shifted out and discarded; digit_count stays at 4.
- Holding a key: exactly one accept per rising edge of valid, no auto-repeat.
- Codes 10..15: ignored; no shift, no pulse.
- enablen=1: no accepts.
  - A key already held when enablen falls is not accepted.
  - It needs a release and a new press, because valid_q already tracks it.
- clr: time_bcd=0 and digit_count=0 next cycle, new_digit=0.
  - clr has priority over a same-cycle accept; that digit is lost.
  - rst has priority over clr.
- Scan:
  - The divider counts 0..SCAN_DIV-1.
  - On wrap, scan index advances 0→1→2→3→0.
- Display outputs, registered one cycle after scan index and time_bcd:
  - an = ~(1<<idx).
  - seg = decode of time_bcd[4*idx+:4].
- Leading-digit blanking: for idx != 0 and idx >= digit_count, seg=7'h7F while an still selects that digit. Digit 0 is always shown, so an empty buffer shows "0".
- Decode table (hex, active-low): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10. Any other nibble gives 7F; this cannot occur internally.
- Reset mid-scan or mid-press:
  - Scan state restarts from idx 0.
  - Because valid_q is cleared, a key held through reset release is accepted once on the first cycle after reset.
- Display always tracks the current buffer and is independent of enablen.

Test Plan:
- Reset, then idle 20 cycles with SCAN_DIV=4. Expect an cycling 1110,1101,1011,0111 every 4 cycles; seg=40 only while an=1110, 7F otherwise; time_bcd=0000.
- Press 1 (held 50 cycles), release, press 2, press 3, release. Expect time_bcd=16'h0123, digit_count=3, exactly 3 new_digit pulses; an=0111 shows 7F, an=1011 shows 79.
- Enter 1,2,3,4,5. Expect time_bcd=16'h2345, digit_count=4, 5 pulses, all four digits lit.
- Assert enablen=1, press 7, deassert enablen while 7 is still held. Expect no change and no pulse until 7 is released and re-pressed; then time_bcd shifts in 7.
- With time_bcd=16'h0042, present bcd=4'hC and valid rising. Expect no change, no pulse.
- Present clr and a valid rising edge of 9 in the same cycle. Expect time_bcd=0, digit_count=0, new_digit=0. Then assert rst mid-scan and expect an=1111 and seg=7F during reset.
